// File: rtl/jtcomsc_snd_pkg.sv
// rtl/jtcomsc_snd_pkg.sv - shared constants for the sound command bridge
// Optional FIFO build: JTCOMSC_SNDCMD_FIFO_EN
package jtcomsc_snd_pkg;

  localparam int SND_DW = 8;

  localparam logic [1:0] INT_IDLE = 2'd0;
  localparam logic [1:0] INT_REQ  = 2'd1;
  localparam logic [1:0] INT_ACKD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = INT_IDLE,
    ST_REQ  = INT_REQ,
    ST_ACKD = INT_ACKD
  } int_state_e;

endpackage

// File: rtl/jtcomsc_snd_fifo.sv
// rtl/jtcomsc_snd_fifo.sv - synchronous command FIFO, built only with JTCOMSC_SNDCMD_FIFO_EN
`ifdef JTCOMSC_SNDCMD_FIFO_EN
module jtcomsc_snd_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [AW:0]   next_count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_acc, pop_acc;

  always_comb begin
    full     = count_q[AW];
    empty    = (count_q == '0);
    pop_acc  = pop & ~empty;
    // a full FIFO still accepts a push when the same clk frees a slot
    push_acc = push & (~full | pop_acc);
    wr_ptr_d = wr_ptr_q + AW'(push_acc);
    rd_ptr_d = rd_ptr_q + AW'(pop_acc);
    count_d  = count_q + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};
    head       = mem_q[rd_ptr_q];
    count      = count_q;
    next_count = count_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`endif

// File: rtl/jtcomsc_snd_cmd.sv
// rtl/jtcomsc_snd_cmd.sv - main-CPU to Z80 sound command latch with level /INT
// JTCOMSC_SNDCMD_FIFO_EN selects a FIFO of 2^FIFO_AW commands instead of one register
module jtcomsc_snd_cmd
  import jtcomsc_snd_pkg::*;
#(
  parameter int DW      = SND_DW,
  parameter int FIFO_AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          snd_cen,
  input  logic          snd_irq,
  input  logic [DW-1:0] snd_latch,
  input  logic          latch_rd,
  input  logic          m1_n,
  input  logic          iorq_n,
  output logic          snd_int_n,
  output logic [DW-1:0] cmd_dout,
  output logic          cmd_pend,
  output logic          overrun
);

  int_state_e state_q, state_d;
  logic       irq_hist_q, irq_hist_d;
  logic       overrun_q, overrun_d;
  logic       new_cmd, rd, ack, iack_cyc;
  logic       pend_nxt;

  always_comb begin
    irq_hist_d = snd_irq;
    new_cmd    = snd_irq & ~irq_hist_q;
    rd         = latch_rd & snd_cen;
    iack_cyc   = ~m1_n & ~iorq_n;
    ack        = snd_cen & iack_cyc;
  end

`ifdef JTCOMSC_SNDCMD_FIFO_EN
  logic [DW-1:0]    fifo_head;
  logic             fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_count, fifo_next_count;

  jtcomsc_snd_fifo #(
    .DW (DW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (new_cmd),
    .push_data  (snd_latch),
    .pop        (rd),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .next_count (fifo_next_count)
  );

  always_comb begin
    overrun_d = overrun_q | (new_cmd & fifo_full & ~(rd & ~fifo_empty));
    pend_nxt  = (fifo_next_count != '0);
    cmd_pend  = (fifo_count != '0);
    // stale storage is masked so an empty FIFO reads as zero
    cmd_dout  = fifo_empty ? '0 : fifo_head;
  end
`else
  logic [DW-1:0] cmd_q, cmd_d;
  logic          pend_q, pend_d;

  always_comb begin
    cmd_d     = cmd_q;
    pend_d    = pend_q;
    overrun_d = overrun_q;
    if (rd) pend_d = 1'b0;
    if (new_cmd) begin
      cmd_d  = snd_latch;
      pend_d = 1'b1;
      // a read in the same clk retires the old byte, so nothing is lost
      if (pend_q && !rd) overrun_d = 1'b1;
    end
    pend_nxt = pend_d;
    cmd_pend = pend_q;
    cmd_dout = cmd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      pend_q <= pend_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pend_nxt) state_d = ST_REQ;
      ST_REQ: begin
        if (ack)           state_d = ST_ACKD;
        else if (!pend_nxt) state_d = ST_IDLE;
      end
      // leave only once the Z80 acknowledge cycle has ended
      ST_ACKD: if (!iack_cyc) state_d = pend_nxt ? ST_REQ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    snd_int_n = (state_q != ST_REQ);
    overrun   = overrun_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      irq_hist_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_hist_q <= irq_hist_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_jtcomsc_snd_cmd.sv
// tb/tb_jtcomsc_snd_cmd.sv - directed self-checking bench for jtcomsc_snd_cmd
// Covers JTCOMSC_SNDCMD_FIFO_EN when that macro is defined
module tb_jtcomsc_snd_cmd;

  logic       clk = 1'b0;
  logic       rst;
  logic       snd_cen;
  logic       snd_irq;
  logic [7:0] snd_latch;
  logic       latch_rd;
  logic       m1_n;
  logic       iorq_n;
  logic       snd_int_n;
  logic [7:0] cmd_dout;
  logic       cmd_pend;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int highs;

  jtcomsc_snd_cmd #(.DW(8), .FIFO_AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .snd_cen   (snd_cen),
    .snd_irq   (snd_irq),
    .snd_latch (snd_latch),
    .latch_rd  (latch_rd),
    .m1_n      (m1_n),
    .iorq_n    (iorq_n),
    .snd_int_n (snd_int_n),
    .cmd_dout  (cmd_dout),
    .cmd_pend  (cmd_pend),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v);
    snd_latch = v;
    snd_irq   = 1'b1;
    tick();
    snd_irq   = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    snd_cen = 1'b1; snd_irq = 1'b0; snd_latch = 8'h00;
    latch_rd = 1'b0; m1_n = 1'b1; iorq_n = 1'b1;
    do_reset();
    check("rst_int_n", 32'(snd_int_n), 32'd1);
    check("rst_dout", 32'(cmd_dout), 32'h00);
    check("rst_pend", 32'(cmd_pend), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);

    // long snd_irq high: one capture only
    snd_latch = 8'h5A; snd_irq = 1'b1;
    tick();
    check("t1_int_n", 32'(snd_int_n), 32'd0);
    check("t1_pend", 32'(cmd_pend), 32'd1);
    check("t1_dout", 32'(cmd_dout), 32'h5A);
    snd_latch = 8'hFF;
    highs = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (snd_int_n) highs++;
    end
    check("t1_int_stays_low", 32'(highs), 32'd0);
    check("t1_no_recapture", 32'(cmd_dout), 32'h5A);
    check("t1_ovr", 32'(overrun), 32'd0);
    snd_irq = 1'b0;
    tick();

    // acknowledge, then consume while the ack cycle is still open
    m1_n = 1'b0; iorq_n = 1'b0;
    tick();
    check("t2_ack_int_n", 32'(snd_int_n), 32'd1);
    check("t2_ack_pend", 32'(cmd_pend), 32'd1);
    check("t2_ack_dout", 32'(cmd_dout), 32'h5A);
    tick(); tick(); tick();
    check("t2_ack_hold", 32'(snd_int_n), 32'd1);
    snd_cen = 1'b0; latch_rd = 1'b1;
    tick();
    check("t2_rd_no_cen", 32'(cmd_pend), 32'd1);
    snd_cen = 1'b1;
    tick();
    check("t2_rd_pend", 32'(cmd_pend), 32'd0);
    latch_rd = 1'b0; m1_n = 1'b1; iorq_n = 1'b1;
    tick();
    tick();
    check("t2_idle_int_n", 32'(snd_int_n), 32'd1);

`ifdef JTCOMSC_SNDCMD_FIFO_EN
    do_reset();
    for (int v = 1; v <= 5; v++) send(8'(v));
    check("f_ovr", 32'(overrun), 32'd1);
    check("f_pend", 32'(cmd_pend), 32'd1);
    check("f_int_n", 32'(snd_int_n), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("f_head", 32'(cmd_dout), 32'(i + 1));
      m1_n = 1'b0; iorq_n = 1'b0;
      tick();
      check("f_ack_int_n", 32'(snd_int_n), 32'd1);
      latch_rd = 1'b1;
      tick();
      latch_rd = 1'b0; m1_n = 1'b1; iorq_n = 1'b1;
      tick();
      check("f_reassert", 32'(snd_int_n), (i < 3) ? 32'd0 : 32'd1);
    end
    check("f_empty_pend", 32'(cmd_pend), 32'd0);
    latch_rd = 1'b1;
    tick();
    latch_rd = 1'b0;
    check("f_pop_empty", 32'(cmd_pend), 32'd0);
`else
    // back-to-back commands with no read
    do_reset();
    send(8'h11);
    check("s_first", 32'(cmd_dout), 32'h11);
    check("s_first_ovr", 32'(overrun), 32'd0);
    send(8'h22);
    check("s_dout", 32'(cmd_dout), 32'h22);
    check("s_ovr", 32'(overrun), 32'd1);
    check("s_pend", 32'(cmd_pend), 32'd1);
    check("s_int_n", 32'(snd_int_n), 32'd0);

    // new command and read in the same clk
    do_reset();
    send(8'h44);
    snd_latch = 8'h33; snd_irq = 1'b1; latch_rd = 1'b1;
    tick();
    check("c_dout", 32'(cmd_dout), 32'h33);
    check("c_pend", 32'(cmd_pend), 32'd1);
    check("c_ovr", 32'(overrun), 32'd0);
    snd_irq = 1'b0; latch_rd = 1'b0;
    tick();
`endif

    // reset in the middle of an outstanding interrupt
    send(8'h66);
    check("r_pre_int_n", 32'(snd_int_n), 32'd0);
    check("r_pre_ovr", 32'(overrun), 32'd1);
    rst = 1'b1;
    tick();
    check("r_int_n", 32'(snd_int_n), 32'd1);
    check("r_pend", 32'(cmd_pend), 32'd0);
    check("r_ovr", 32'(overrun), 32'd0);
    check("r_dout", 32'(cmd_dout), 32'h00);
    rst = 1'b0;
    tick();
    check("r_after_int_n", 32'(snd_int_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtcomsc_snd_cmd.md
Name: jtcomsc_snd_cmd

Overview:
- Bridges the main-CPU sound command (snd_latch byte plus snd_irq strobe from the main decoder) into the Z80 sound CPU domain.
- Captures the command byte and holds a level interrupt to the Z80 until the Z80 acknowledges it.
- Presents the byte on a read port decoded by the sound-side decoder.
- Sits between the main address decoder and the sound CPU/decoder.

Parameters:
- DW, 8, command data width.
- FIFO_AW, 2, log2 of FIFO depth; used only with JTCOMSC_SNDCMD_FIFO_EN.

Ports:
- clk  in  1  24 MHz system clock
- rst  in  1  synchronous reset, active high
- snd_cen  in  1  sound CPU clock enable
- snd_irq  in  1  command strobe from main decoder; rising edge means a new command
- snd_latch  in  DW  command byte; stable when snd_irq rises
- latch_rd  in  1  sound decoder read strobe of the command port
- m1_n  in  1  Z80 M1
- iorq_n  in  1  Z80 IORQ
- snd_int_n  out  1  Z80 /INT, level, active low
- cmd_dout  out  DW  command byte to the sound CPU data mux
- cmd_pend  out  1  a command is waiting
- overrun  out  1  sticky flag: a command was lost

Behaviour:
- Reset values:
  - snd_int_n=1, cmd_dout=0, cmd_pend=0, overrun=0.
  - Edge detector history=0.
  - FIFO pointers=0.
- Edge detect:
  - snd_irq is sampled every clk into a 1-bit history register.
  - new_cmd = snd_irq & ~history, one clk wide.
  - snd_irq held high for many clocks produces exactly one new_cmd.
- Capture: on new_cmd, store snd_latch in the same clk. No snd_cen gating, because the main side is independent.
- Interrupt assertion:
  - snd_int_n goes low on the clk after new_cmd.
  - It stays low while cmd_pend=1.
- Interrupt acknowledge:
  - ack = snd_cen & ~m1_n & ~iorq_n.
  - ack rises → snd_int_n=1 on the next clk, in both modes.
  - ack does not modify the data.
  - In FIFO mode, snd_int_n re-asserts 1 clk after the ack cycle ends if entries remain.
- Read:
  - latch_rd & snd_cen pops or consumes the command.
  - cmd_dout always shows the current head byte; in single mode, the last captured byte.
- Single-register mode (macro off):
  - new_cmd sets cmd_pend=1 and loads cmd_dout.
  - latch_rd&snd_cen clears cmd_pend.
  - new_cmd while cmd_pend=1 overwrites the byte and sets overrun.
  - new_cmd and latch_rd in the same clk: the new byte wins, cmd_pend stays 1, no overrun.
- State machine for snd_int_n:
  - IDLE(int_n=1) → REQ(int_n=0) on pending command.
  - REQ → ACKD(int_n=1) on ack.
  - ACKD → IDLE when ack deasserts and no command is pending.
  - ACKD → REQ when ack deasserts and a command is pending.
  - Any new_cmd in ACKD is held until ACKD exits.
- Reset mid-operation: all state returns to reset values in one clk; a pending command is discarded.
- overrun clears only on rst.

Optional Feature:
- JTCOMSC_SNDCMD_FIFO_EN defined:
  - Commands go into a 2^FIFO_AW-entry FIFO with wrap-around pointers and an occupancy counter FIFO_AW+1 bits wide.
  - cmd_pend = count!=0; cmd_dout = head entry.
  - latch_rd&snd_cen pops; popping an empty FIFO does nothing.
  - new_cmd when full drops the byte and sets overrun.
  - Push and pop in the same clk: count unchanged, and the pop head is read before the push.
- Not defined: single-register mode as above; FIFO_AW ignored.

Decomposition:
- Shared package jtcomsc_snd_pkg holds:
  - localparams for the interrupt states IDLE/REQ/ACKD.
  - the default DW.
- One natural sub-module: jtcomsc_snd_fifo, a synchronous FIFO with push/pop/full/empty/count. It is instantiated only under the macro.

Test Plan:
- Reset, then snd_latch=8'h5A and snd_irq held high 100 clk → one capture. snd_int_n=0 from the clk after the edge; cmd_dout=8'h5A; cmd_pend=1.
- With a command pending, drive m1_n=0, iorq_n=0 for 4 clk with snd_cen → snd_int_n=1 within 1 clk; cmd_pend remains 1. Then latch_rd&snd_cen → cmd_pend=0.
- Single mode: commands 8'h11 then 8'h22 sent without a read → cmd_dout=8'h22, overrun=1, a single interrupt.
- new_cmd (8'h33) and latch_rd in the same clk → cmd_dout=8'h33, cmd_pend=1, overrun=0.
- FIFO mode (FIFO_AW=2): send 8'h01..8'h05 → the first four are stored, overrun=1. Four reads return 01,02,03,04, then cmd_pend=0 and snd_int_n=1. After each ack, int re-asserts while entries remain.
- Assert rst while snd_int_n=0 → next clk: snd_int_n=1, cmd_pend=0, overrun=0, cmd_dout=0.
